// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared encodings for the microcode sequencer -- next-state
// select codes, RISC-V major opcodes, microaddress entry points, FSM states.
package micro_seq_pkg;

   // cw_nssel field encodings
   localparam logic [1:0] NS_JUMP = 2'b00;
   localparam logic [1:0] NS_DISP = 2'b01;
   localparam logic [1:0] NS_LDST = 2'b10;
   localparam logic [1:0] NS_COND = 2'b11;

   // RISC-V major opcodes (IR[6:0])
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Microcode entry points in the control store
   localparam int UA_START0 = 0;
   localparam int UA_ADS1   = 1;
   localparam int UA_LUI1   = 2;
   localparam int UA_STR1   = 3;
   localparam int UA_AUIPC1 = 4;
   localparam int UA_OPRR1  = 5;
   localparam int UA_OPRRI1 = 7;
   localparam int UA_LDI1   = 9;
   localparam int UA_BCH1   = 12;
   localparam int UA_JAS1   = 16;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_TRAP  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/micro_dispatch.sv
// micro_dispatch: opcode decode for both dispatch levels. The first level maps
// the major opcode to its microroutine; loads and stores share the address-
// calculation routine and split later in the second (ld/st) level.
module micro_dispatch
   import micro_seq_pkg::*;
#(
   parameter int UA_W = 5
) (
   input  logic [6:0]      opcode,
   output logic [UA_W-1:0] disp_ua,
   output logic            disp_ok,
   output logic [UA_W-1:0] ldst_ua,
   output logic            ldst_ok
);

   // first-level opcode dispatch
   always_comb begin
      disp_ua = '0;
      disp_ok = 1'b1;
      case (opcode)
         OP_LUI:            disp_ua = UA_W'(UA_LUI1);
         OP_LOAD, OP_STORE: disp_ua = UA_W'(UA_ADS1);
         OP_AUIPC:          disp_ua = UA_W'(UA_AUIPC1);
         OP_OP:             disp_ua = UA_W'(UA_OPRR1);
         OP_OPIMM:          disp_ua = UA_W'(UA_OPRRI1);
         OP_BRANCH:         disp_ua = UA_W'(UA_BCH1);
         OP_JAL:            disp_ua = UA_W'(UA_JAS1);
         default:           disp_ok = 1'b0;
      endcase
   end

   // second-level load/store split after the shared address calculation
   always_comb begin
      ldst_ua = '0;
      ldst_ok = 1'b1;
      case (opcode)
         OP_STORE: ldst_ua = UA_W'(UA_STR1);
         OP_LOAD:  ldst_ua = UA_W'(UA_LDI1);
         default:  ldst_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microaddress generator for the microcode control store.
// uaddr is combinational from the current control word so the store issues one
// microword per cycle. Handles jump, opcode dispatch, ld/st split, conditional
// branch, memory-wait stall and illegal-opcode trap.
// Optional: define MICRO_SEQ_PERF_EN to add the ucycle_cnt/instr_cnt counters.
module micro_sequencer
   import micro_seq_pkg::*;
#(
   parameter int              UA_W        = 5,
   parameter logic [UA_W-1:0] RESET_UADDR = '0,
   parameter logic [UA_W-1:0] TRAP_UADDR  = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      cw_nssel,
   input  logic [4:0]      cw_dbin,
   input  logic [2:0]      cw_memcntl,
   input  logic [6:0]      ir_opcode,
   input  logic            br_cond,
   input  logic            mem_ready,
   input  logic            trap_clr,
   output logic [UA_W-1:0] uaddr,
   output logic [UA_W-1:0] upc,
   output logic            stall,
   output logic            trap
`ifdef MICRO_SEQ_PERF_EN
  ,output logic [31:0]     ucycle_cnt,
   output logic [31:0]     instr_cnt
`endif
);

   seq_state_e      state_q, state_d;
   logic [UA_W-1:0] disp_ua, ldst_ua;
   logic            disp_ok, ldst_ok;
   logic            mem_wait;

   micro_dispatch #(.UA_W(UA_W)) u_dispatch (
      .opcode  (ir_opcode),
      .disp_ua (disp_ua),
      .disp_ok (disp_ok),
      .ldst_ua (ldst_ua),
      .ldst_ok (ldst_ok)
   );

   // mem_ready only matters while the current word actually touches memory
   assign mem_wait = (cw_memcntl != 3'b000) && !mem_ready;

   // next-address and next-state decode; reset beats trap_clr beats stall beats nssel
   always_comb begin
      state_d = state_q;
      uaddr   = upc;
      if (!rst_n) begin
         uaddr   = RESET_UADDR;
         state_d = ST_RST;
      end else begin
         case (state_q)
            ST_RST: begin
               uaddr   = RESET_UADDR;
               state_d = ST_RUN;
            end
            ST_TRAP: begin
               if (trap_clr) begin
                  uaddr   = RESET_UADDR;
                  state_d = ST_RUN;
               end else begin
                  uaddr   = TRAP_UADDR;
               end
            end
            default: begin
               if (mem_wait) begin
                  // re-fetch the word we are on until memory answers
                  uaddr   = upc;
                  state_d = ST_STALL;
               end else begin
                  state_d = ST_RUN;
                  case (cw_nssel)
                     NS_JUMP: uaddr = UA_W'(cw_dbin);
                     NS_DISP: begin
                        if (disp_ok) begin
                           uaddr = disp_ua;
                        end else begin
                           uaddr   = TRAP_UADDR;
                           state_d = ST_TRAP;
                        end
                     end
                     NS_LDST: begin
                        if (ldst_ok) begin
                           uaddr = ldst_ua;
                        end else begin
                           uaddr   = TRAP_UADDR;
                           state_d = ST_TRAP;
                        end
                     end
                     default: uaddr = UA_W'({cw_dbin[4:1], br_cond});
                  endcase
               end
            end
         endcase
      end
   end

   // state, issued-address copy and registered status flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RST;
         upc     <= RESET_UADDR;
         stall   <= 1'b0;
         trap    <= 1'b0;
      end else begin
         state_q <= state_d;
         upc     <= uaddr;
         stall   <= (state_d == ST_STALL);
         trap    <= (state_d == ST_TRAP);
      end
   end

`ifdef MICRO_SEQ_PERF_EN
   logic active;
   logic disp_fire;

   assign active    = (state_q == ST_RUN) || (state_q == ST_STALL);
   assign disp_fire = rst_n && active && !mem_wait && (cw_nssel == NS_DISP) && disp_ok;

   // performance counters; they hold while trapped or in reset state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ucycle_cnt <= '0;
         instr_cnt  <= '0;
      end else if (active) begin
         ucycle_cnt <= ucycle_cnt + 32'd1;
         if (disp_fire) instr_cnt <= instr_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed stimulus with literal expectations, plus a
// table-driven behavioural model checked against the DUT every cycle.
module tb_micro_sequencer;

   localparam int TB_RESET_UA = 0;
   localparam int TB_TRAP_UA  = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cw_nssel = '0;
   logic [4:0] cw_dbin = '0;
   logic [2:0] cw_memcntl = '0;
   logic [6:0] ir_opcode = '0;
   logic       br_cond = 1'b0;
   logic       mem_ready = 1'b0;
   logic       trap_clr = 1'b0;
   logic [4:0] uaddr, upc;
   logic       stall, trap;
`ifdef MICRO_SEQ_PERF_EN
   logic [31:0] ucycle_cnt, instr_cnt;
`endif

   micro_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cw_nssel   (cw_nssel),
      .cw_dbin    (cw_dbin),
      .cw_memcntl (cw_memcntl),
      .ir_opcode  (ir_opcode),
      .br_cond    (br_cond),
      .mem_ready  (mem_ready),
      .trap_clr   (trap_clr),
      .uaddr      (uaddr),
      .upc        (upc),
      .stall      (stall),
      .trap       (trap)
`ifdef MICRO_SEQ_PERF_EN
     ,.ucycle_cnt (ucycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // model: opcode tables (-1 = illegal), phase 0 = just reset, 1 = running, 2 = trapped
   int   disp_tab [128];
   int   ldst_tab [128];
   int   m_phase = 0;
   bit   m_stall = 1'b0;
   int   m_upc   = 0;
`ifdef MICRO_SEQ_PERF_EN
   logic [31:0] m_ucnt = '0;
   logic [31:0] m_icnt = '0;
`endif

   int    n_pass = 0;
   int    n_total = 0;
   bit    chk_on = 1'b0;
   int    lit_ua = -1;
   int    lit_st = -1;
   int    lit_tr = -1;
   bit    lit_cnt0 = 1'b0;
   string lit_nm = "";

   function automatic bit f_wait();
      return (cw_memcntl != 3'd0) && (mem_ready == 1'b0);
   endfunction

   function automatic bit f_illegal();
      return ((cw_nssel == 2'd1) && (disp_tab[int'(ir_opcode)] < 0)) ||
             ((cw_nssel == 2'd2) && (ldst_tab[int'(ir_opcode)] < 0));
   endfunction

   function automatic int f_ua();
      int t;
      if (!rst_n)            return TB_RESET_UA;
      if (m_phase == 0)      return TB_RESET_UA;
      if (m_phase == 2)      return trap_clr ? TB_RESET_UA : TB_TRAP_UA;
      if (f_wait())          return m_upc;
      if (f_illegal())       return TB_TRAP_UA;
      if (cw_nssel == 2'd0)  return int'(cw_dbin);
      if (cw_nssel == 2'd1)  return disp_tab[int'(ir_opcode)];
      if (cw_nssel == 2'd2)  return ldst_tab[int'(ir_opcode)];
      t = (int'(cw_dbin) / 2) * 2 + int'(br_cond);
      return t % 32;
   endfunction

   function automatic int f_phase();
      if (!rst_n)       return 0;
      if (m_phase == 0) return 1;
      if (m_phase == 2) return trap_clr ? 1 : 2;
      if (f_wait())     return 1;
      if (f_illegal())  return 2;
      return 1;
   endfunction

   function automatic bit f_stall();
      return rst_n && (m_phase == 1) && f_wait();
   endfunction

`ifdef MICRO_SEQ_PERF_EN
   function automatic bit f_disp();
      return rst_n && (m_phase == 1) && !f_wait() && (cw_nssel == 2'd1) &&
             (disp_tab[int'(ir_opcode)] >= 0);
   endfunction
`endif

   // advance the model on each clock edge from the inputs present at that edge
   always @(posedge clk) begin
      int ua, ph;
      bit st;
      ua = f_ua();
      ph = f_phase();
      st = f_stall();
`ifdef MICRO_SEQ_PERF_EN
      if (!rst_n) begin
         m_ucnt = '0;
         m_icnt = '0;
      end else begin
         if (m_phase == 1) m_ucnt = m_ucnt + 32'd1;
         if (f_disp())     m_icnt = m_icnt + 32'd1;
      end
`endif
      m_upc   = ua;
      m_phase = ph;
      m_stall = st;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // compare DUT against model every cycle, plus any literal expectation for this cycle
   always @(negedge clk) begin
      if (chk_on) begin
         chk("model.uaddr", 32'(uaddr), 32'(f_ua()));
         chk("model.upc",   32'(upc),   32'(m_upc));
         chk("model.stall", 32'(stall), 32'(m_stall));
         chk("model.trap",  32'(trap),  32'(m_phase == 2));
`ifdef MICRO_SEQ_PERF_EN
         chk("model.ucycle_cnt", ucycle_cnt, m_ucnt);
         chk("model.instr_cnt",  instr_cnt,  m_icnt);
         if (lit_cnt0) begin
            chk({lit_nm, ".ucycle_cnt"}, ucycle_cnt, 32'd0);
            chk({lit_nm, ".instr_cnt"},  instr_cnt,  32'd0);
         end
`endif
         if (lit_ua >= 0) chk({lit_nm, ".uaddr"}, 32'(uaddr), 32'(lit_ua));
         if (lit_st >= 0) chk({lit_nm, ".stall"}, 32'(stall), 32'(lit_st));
         if (lit_tr >= 0) chk({lit_nm, ".trap"},  32'(trap),  32'(lit_tr));
      end
   end

   // one cycle of stimulus; eua/est/etr < 0 means no literal expectation
   task automatic step(input string nm, input int ns, input int db, input int mc, input int op,
                       input int br, input int rdy, input int clr, input int rn,
                       input int eua, input int est, input int etr, input bit c0 = 1'b0);
      @(posedge clk);
      #1;
      cw_nssel   = 2'(ns);
      cw_dbin    = 5'(db);
      cw_memcntl = 3'(mc);
      ir_opcode  = 7'(op);
      br_cond    = 1'(br);
      mem_ready  = 1'(rdy);
      trap_clr   = 1'(clr);
      rst_n      = 1'(rn);
      lit_nm     = nm;
      lit_ua     = eua;
      lit_st     = est;
      lit_tr     = etr;
      lit_cnt0   = c0;
   endtask

   int dops [8] = '{'h37, 'h03, 'h23, 'h17, 'h33, 'h13, 'h63, 'h6f};
   int duas [8] = '{2, 1, 1, 4, 5, 7, 12, 16};

   initial begin
      foreach (disp_tab[i]) disp_tab[i] = -1;
      foreach (ldst_tab[i]) ldst_tab[i] = -1;
      disp_tab['h37] = 2;  disp_tab['h03] = 1;  disp_tab['h23] = 1;  disp_tab['h17] = 4;
      disp_tab['h33] = 5;  disp_tab['h13] = 7;  disp_tab['h63] = 12; disp_tab['h6f] = 16;
      ldst_tab['h23] = 3;  ldst_tab['h03] = 9;

      @(posedge clk);
      chk_on = 1'b1;
      //    name        ns db mc op    br rdy clr rn  ua  st  tr
      step("rst0",      0, 0, 0, 0,    0, 0,  0,  0,  0, -1, -1);
      step("rst1",      0, 0, 0, 0,    0, 0,  0,  0,  0,  0,  0, 1'b1);
      step("start0",    0, 0, 0, 0,    0, 0,  0,  1,  0,  0,  0);
      step("jump23",    0, 23, 0, 0,   0, 0,  0,  1, 23,  0,  0);
      step("disp_op",   1, 0, 0, 'h33, 0, 0,  0,  1,  5, -1, -1);
      step("disp_ld",   1, 0, 0, 'h03, 0, 0,  0,  1,  1, -1, -1);
      step("ldst_ld",   2, 0, 0, 'h03, 0, 0,  0,  1,  9, -1, -1);
      step("ldst_st",   2, 0, 0, 'h23, 0, 0,  0,  1,  3, -1, -1);
      foreach (dops[i]) step($sformatf("disp%0d", i), 1, 0, 0, dops[i], 0, 0, 0, 1, duas[i], 0, 0);
      step("bch_nt",    3, 14, 0, 0,   0, 0,  0,  1, 14, -1, -1);
      step("bch_b0",    3, 15, 0, 0,   0, 0,  0,  1, 14, -1, -1);
      step("bch_tk",    3, 14, 0, 0,   1, 0,  0,  1, 15, -1, -1);
      step("stallA",    0, 20, 2, 0,   0, 0,  0,  1, 15,  0, -1);
      step("stallB",    0, 20, 2, 0,   0, 0,  0,  1, 15,  1, -1);
      step("stallC",    0, 20, 2, 0,   0, 0,  0,  1, 15,  1, -1);
      step("stallD",    0, 20, 2, 0,   0, 1,  0,  1, 20,  1, -1);
      step("nomem",     0, 21, 0, 0,   0, 0,  0,  1, 21,  0, -1);
      step("illegal",   1, 0, 0, 'h7f, 0, 0,  0,  1,  0, -1,  0);
      repeat (5) step("trapped", 0, 9, 0, 0, 0, 0, 0, 1, 0, -1, 1);
      step("trapclr",   0, 9, 0, 0,    0, 0,  1,  1,  0, -1,  1);
      step("rerun",     0, 6, 0, 0,    0, 0,  0,  1,  6, -1,  0);
      step("ldst_bad",  2, 0, 0, 'h33, 0, 0,  0,  1,  0, -1,  0);
      step("trapclr2",  0, 7, 0, 0,    0, 0,  1,  1,  0, -1,  1);
      step("clr_run",   0, 11, 0, 0,   0, 0,  1,  1, 11, -1,  0);
      step("ill_wait",  1, 0, 1, 'h7f, 0, 0,  0,  1, 11,  0,  0);
      step("ill_rdy",   1, 0, 1, 'h7f, 0, 1,  0,  1,  0,  1,  0);
      step("ill_trap",  0, 3, 0, 0,    0, 0,  0,  1,  0,  0,  1);
      step("trapclr3",  0, 3, 0, 0,    0, 0,  1,  1,  0, -1,  1);
      step("wrap31",    3, 31, 0, 0,   1, 0,  0,  1, 31, -1,  0);
      step("st_rA",     0, 30, 3, 0,   0, 0,  0,  1, 31,  0, -1);
      step("st_rB",     0, 30, 3, 0,   0, 0,  0,  1, 31,  1, -1);
      step("st_rst",    0, 30, 3, 0,   0, 0,  0,  0,  0,  1, -1);
      step("st_rst2",   0, 30, 3, 0,   0, 0,  0,  0,  0,  0,  0, 1'b1);
      step("st_rel",    0, 0, 0, 0,    0, 0,  0,  1,  0,  0,  0, 1'b1);
      step("post_rst",  0, 5, 0, 0,    0, 0,  0,  1,  5,  0,  0);
      step("ill_zero",  1, 0, 0, 0,    0, 0,  0,  1,  0, -1,  0);
      step("tr_rst",    0, 8, 0, 0,    0, 0,  0,  0,  0, -1,  1);
      step("tr_rel",    0, 8, 0, 0,    0, 0,  0,  1,  0,  0,  0, 1'b1);
      step("tr_run",    0, 8, 0, 0,    0, 0,  0,  1,  8,  0,  0);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
